// File: rtl/aesl_deadlock_watchdog.sv
// Deadlock watchdog for the pixl_to_symbol co-simulation bench: confirms a persistent,
// stable blocked condition and hands the channel signature to the reporter.
module aesl_deadlock_watchdog #(
  parameter int INFO_W         = 4,
  parameter int INST_N         = 3,
  parameter int CONFIRM_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              block_in,
  input  logic [INFO_W-1:0] axis_info_in,
  input  logic [INST_N-1:0] inst_idle_sigs,
  output logic              report_valid,
  input  logic              report_ready,
  output logic [INFO_W-1:0] report_info,
  output logic              deadlock,
  output logic [CNT_W-1:0]  persist_cnt,
  output logic [7:0]        false_alarms,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_SUSPECT = 3'd2,
    ST_REPORT  = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LP_CONFIRM = CNT_W'(CONFIRM_CYCLES);
  localparam logic [CNT_W-1:0] LP_LAST    = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

  state_t            r_state;
  logic              r_report_valid;
  logic [INFO_W-1:0] r_report_info;
  logic              r_deadlock;
  logic [CNT_W-1:0]  r_persist_cnt;
  logic [7:0]        r_false_alarms;
  logic [INFO_W-1:0] r_cand_info;

  logic w_all_idle;
  logic w_blocked;

  // A block with every instance idle means the design finished, not that it hung.
  assign w_all_idle = &inst_idle_sigs;
  assign w_blocked  = block_in & ~w_all_idle;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_report_valid <= 1'b0;
      r_report_info  <= '0;
      r_deadlock     <= 1'b0;
      r_persist_cnt  <= '0;
      r_false_alarms <= '0;
      r_cand_info    <= '0;
    end else if (!enable) begin
      // Leaving the run window drops any pending report; the alarm tally survives.
      r_state        <= ST_IDLE;
      r_report_valid <= 1'b0;
      r_report_info  <= '0;
      r_deadlock     <= 1'b0;
      r_persist_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state       <= ST_RUN;
          r_persist_cnt <= '0;
        end

        ST_RUN: begin
          if (w_blocked) begin
            r_state       <= ST_SUSPECT;
            r_persist_cnt <= LP_ONE;
            r_cand_info   <= axis_info_in;
          end
        end

        ST_SUSPECT: begin
          if (!w_blocked) begin
            r_state       <= ST_RUN;
            r_persist_cnt <= '0;
            if (r_false_alarms != 8'hFF) begin
              r_false_alarms <= r_false_alarms + 8'd1;
            end
          end else if (axis_info_in != r_cand_info) begin
            // A new signature restarts the window and counts as its first sample.
            r_persist_cnt <= LP_ONE;
            r_cand_info   <= axis_info_in;
          end else if (r_persist_cnt == LP_LAST) begin
            r_state        <= ST_REPORT;
            r_persist_cnt  <= LP_CONFIRM;
            r_report_info  <= r_cand_info;
            r_report_valid <= 1'b1;
            r_deadlock     <= 1'b1;
          end else begin
            r_persist_cnt <= r_persist_cnt + LP_ONE;
          end
        end

        ST_REPORT: begin
          if (report_ready) begin
            r_state        <= ST_HALT;
            r_report_valid <= 1'b0;
          end
        end

        ST_HALT: begin
          r_state <= ST_HALT;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign report_valid = r_report_valid;
  assign report_info  = r_report_info;
  assign deadlock     = r_deadlock;
  assign persist_cnt  = r_persist_cnt;
  assign false_alarms = r_false_alarms;
  assign state        = r_state;

endmodule

// File: tb/tb_aesl_deadlock_watchdog.sv
// Scoreboard bench for aesl_deadlock_watchdog: directed scenarios push expected reports,
// a negedge monitor checks every presented report against the queue.
module tb_aesl_deadlock_watchdog;

  localparam int INFO_W = 4;
  localparam int INST_N = 3;
  localparam int CONF   = 8;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              block_in;
  logic [INFO_W-1:0] axis_info_in;
  logic [INST_N-1:0] inst_idle_sigs;
  logic              report_valid;
  logic              report_ready;
  logic [INFO_W-1:0] report_info;
  logic              deadlock;
  logic [CNT_W-1:0]  persist_cnt;
  logic [7:0]        false_alarms;
  logic [2:0]        state;

  logic [INFO_W-1:0] sbQueue[$];
  int checkCount = 0;
  int errorCount = 0;

  aesl_deadlock_watchdog #(
    .INFO_W(INFO_W), .INST_N(INST_N), .CONFIRM_CYCLES(CONF), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .block_in(block_in),
    .axis_info_in(axis_info_in), .inst_idle_sigs(inst_idle_sigs),
    .report_valid(report_valid), .report_ready(report_ready), .report_info(report_info),
    .deadlock(deadlock), .persist_cnt(persist_cnt), .false_alarms(false_alarms),
    .state(state)
  );

  always #5 clock = ~clock;

  // Any presented report must match the oldest expected one; a handshake retires it.
  always @(negedge clock) begin
    if (!reset && report_valid) begin
      checkCount++;
      if (sbQueue.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL spurious_report actual valid=1 info=%0h expected no report", report_info);
      end else begin
        if (report_info !== sbQueue[0]) begin
          errorCount++;
          $display("[TB] FAIL report_info actual=%0h expected=%0h", report_info, sbQueue[0]);
        end
        if (report_ready && enable) void'(sbQueue.pop_front());
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic blk, input logic [INFO_W-1:0] info,
                               input logic [INST_N-1:0] idle, input logic rdy, input int cycles);
    enable         = en;
    block_in       = blk;
    axis_info_in   = info;
    inst_idle_sigs = idle;
    report_ready   = rdy;
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic waitReport(output int n);
    n = 0;
    while (!report_valid && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic checkCleared(input string tag, input logic [7:0] expFa);
    checkOutput({tag, "_state"}, 32'(state), 32'd0);
    checkOutput({tag, "_valid"}, 32'(report_valid), 32'd0);
    checkOutput({tag, "_info"}, 32'(report_info), 32'd0);
    checkOutput({tag, "_deadlock"}, 32'(deadlock), 32'd0);
    checkOutput({tag, "_persist"}, 32'(persist_cnt), 32'd0);
    checkOutput({tag, "_false_alarms"}, 32'(false_alarms), 32'(expFa));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=expired required=finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 2);
    reset = 1'b0;
    checkCleared("reset", 8'd0);

    // Basic confirm with ready held early: ready before REPORT must not matter.
    applyStimulus(1'b1, 1'b0, 4'hD, 3'b000, 1'b1, 1);
    checkOutput("t1_run", 32'(state), 32'd1);
    sbQueue.push_back(4'hD);
    applyStimulus(1'b1, 1'b1, 4'hD, 3'b000, 1'b1, 0);
    waitReport(n);
    checkOutput("t1_latency", 32'(n), 32'(CONF));
    checkOutput("t1_state", 32'(state), 32'd3);
    checkOutput("t1_persist", 32'(persist_cnt), 32'(CONF));
    checkOutput("t1_deadlock", 32'(deadlock), 32'd1);
    applyStimulus(1'b1, 1'b1, 4'hD, 3'b000, 1'b1, 1);
    checkOutput("t1_halt", 32'(state), 32'd4);
    checkOutput("t1_valid_low", 32'(report_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 4'h3, 3'b000, 1'b0, 3);
    checkOutput("t1_halt_hold", 32'(state), 32'd4);
    checkOutput("t1_halt_info", 32'(report_info), 32'hD);
    applyStimulus(1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 1);
    checkCleared("t1_disable", 8'd0);

    // All-idle exemption.
    applyStimulus(1'b1, 1'b0, 4'h5, 3'b000, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 4'h5, 3'b111, 1'b0, 20);
    checkOutput("t4_state_run", 32'(state), 32'd1);
    checkOutput("t4_fa", 32'(false_alarms), 32'd0);
    checkOutput("t4_persist", 32'(persist_cnt), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'h5, 3'b110, 1'b0, 1);
    checkOutput("t4_suspect", 32'(state), 32'd2);
    checkOutput("t4_persist1", 32'(persist_cnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 4'h5, 3'b110, 1'b0, 1);
    checkOutput("t4_abort", 32'(state), 32'd1);
    checkOutput("t4_fa1", 32'(false_alarms), 32'd1);

    // Enable drop during SUSPECT.
    applyStimulus(1'b1, 1'b1, 4'hD, 3'b000, 1'b0, 3);
    checkOutput("t6a_persist3", 32'(persist_cnt), 32'd3);
    applyStimulus(1'b0, 1'b1, 4'hD, 3'b000, 1'b0, 1);
    checkCleared("t6a_disable", 8'd1);

    // Glitch aborts until the alarm counter saturates.
    applyStimulus(1'b1, 1'b0, 4'hD, 3'b000, 1'b0, 1);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, 4'hD, 3'b000, 1'b0, 5);
      applyStimulus(1'b1, 1'b0, 4'hD, 3'b000, 1'b0, 1);
      if (i == 0) begin
        checkOutput("t2_state", 32'(state), 32'd1);
        checkOutput("t2_fa2", 32'(false_alarms), 32'd2);
      end
      if (i == 252) checkOutput("t2_fa254", 32'(false_alarms), 32'd254);
      if (i == 253) checkOutput("t2_fa255", 32'(false_alarms), 32'd255);
    end
    checkOutput("t2_fa_sat", 32'(false_alarms), 32'd255);
    checkOutput("t2_no_deadlock", 32'(deadlock), 32'd0);

    // Signature change restarts the window, then backpressure.
    applyStimulus(1'b1, 1'b1, 4'hD, 3'b000, 1'b0, 6);
    checkOutput("t3_persist6", 32'(persist_cnt), 32'd6);
    sbQueue.push_back(4'hB);
    applyStimulus(1'b1, 1'b1, 4'hB, 3'b000, 1'b0, 1);
    checkOutput("t3_restart", 32'(persist_cnt), 32'd1);
    checkOutput("t3_suspect", 32'(state), 32'd2);
    waitReport(n);
    checkOutput("t3_latency", 32'(n + 1), 32'(CONF));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, i[0], 4'(i), 3'(i), 1'b0, 1);
      checkOutput("t5_valid_hold", 32'(report_valid), 32'd1);
      checkOutput("t5_info_hold", 32'(report_info), 32'hB);
    end
    applyStimulus(1'b1, 1'b1, 4'hB, 3'b000, 1'b1, 1);
    checkOutput("t5_halt", 32'(state), 32'd4);
    checkOutput("t5_valid_low", 32'(report_valid), 32'd0);
    checkOutput("t5_deadlock", 32'(deadlock), 32'd1);
    checkOutput("t5_info", 32'(report_info), 32'hB);

    // Enable drop coinciding with ready in REPORT: the report is dropped.
    applyStimulus(1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 4'h0, 3'b000, 1'b0, 1);
    sbQueue.push_back(4'hD);
    applyStimulus(1'b1, 1'b1, 4'hD, 3'b000, 1'b0, 0);
    waitReport(n);
    checkOutput("t6b_latency", 32'(n), 32'(CONF));
    applyStimulus(1'b0, 1'b1, 4'hD, 3'b000, 1'b1, 1);
    if (sbQueue.size() != 0) void'(sbQueue.pop_front());
    checkCleared("t6b_disable", 8'd255);

    // Reset in HALT.
    applyStimulus(1'b1, 1'b0, 4'h0, 3'b000, 1'b0, 1);
    sbQueue.push_back(4'h6);
    applyStimulus(1'b1, 1'b1, 4'h6, 3'b000, 1'b0, 0);
    waitReport(n);
    applyStimulus(1'b1, 1'b1, 4'h6, 3'b000, 1'b1, 1);
    checkOutput("t6c_halt", 32'(state), 32'd4);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'h6, 3'b000, 1'b1, 1);
    checkCleared("t6c_reset", 8'd0);
    reset = 1'b0;

    checkOutput("queue_empty", 32'(sbQueue.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
